// File: rtl/pipe_arb_pkg.sv
// Shared types and constants for the IF/MEM unified-memory arbiter.
package pipe_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DATA  = 2'd1,
        FETCH = 2'd2
    } arb_state_e;

    localparam logic OWN_IF = 1'b0;
    localparam logic OWN_DM = 1'b1;

    localparam logic [31:0] ARB_ABORT_DATA = 32'hDEAD_BEEF;

    function automatic logic state_owner(input arb_state_e s);
        return (s == DATA) ? OWN_DM : OWN_IF;
    endfunction

endpackage

// File: rtl/pipe_arb_perf_cnt.sv
// Saturating 16-bit event counter with synchronous clear.
// Latency: count visible one cycle after inc; holds at 16'hFFFF.
module pipe_arb_perf_cnt (
    input  logic        clock,
    input  logic        clr,
    input  logic        inc,
    output logic [15:0] cnt
);

    logic [15:0] cnt_q;
    logic [15:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (inc && (cnt_q != 16'hFFFF)) begin
            cnt_d = cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clock) begin
        if (clr) begin
            cnt_q <= 16'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/pipe_mem_arbiter.sv
// Arbitrates one variable-latency memory between IF fetch and MEM data ports.
// Data beats fetch; optional perf counters under PIPE_ARB_PERF_CNT_EN.
module pipe_mem_arbiter
    import pipe_arb_pkg::*;
#(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int TIMEOUT = 255
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    output logic [DW-1:0] if_rdata,
    output logic          if_ready,
    input  logic          dm_req,
    input  logic          dm_we,
    input  logic [AW-1:0] dm_addr,
    input  logic [DW-1:0] dm_wdata,
    output logic [DW-1:0] dm_rdata,
    output logic          dm_ready,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    input  logic          mem_valid,
    output logic          err
`ifdef PIPE_ARB_PERF_CNT_EN
    ,
    output logic [15:0]   conflict_cnt,
    output logic [15:0]   fetch_stall_cnt
`endif
);

    localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
    localparam logic [CW-1:0] TMO_LAST = CW'(TIMEOUT - 1);

    arb_state_e    state_q, state_d;
    logic          mem_en_q, mem_en_d;
    logic          mem_we_q, mem_we_d;
    logic [AW-1:0] mem_addr_q, mem_addr_d;
    logic [DW-1:0] mem_wdata_q, mem_wdata_d;
    logic [DW-1:0] if_rdata_q, if_rdata_d;
    logic [DW-1:0] dm_rdata_q, dm_rdata_d;
    logic          if_ready_q, if_ready_d;
    logic          dm_ready_q, dm_ready_d;
    logic          err_q, err_d;
    logic [CW-1:0] tmo_q, tmo_d;

    // A requester still showing its ready pulse has a stale req.
    logic dm_go, if_go;
    assign dm_go = dm_req & ~dm_ready_q;
    assign if_go = if_req & ~if_ready_q;

    always_comb begin
        state_d     = state_q;
        mem_en_d    = mem_en_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        if_rdata_d  = if_rdata_q;
        dm_rdata_d  = dm_rdata_q;
        if_ready_d  = 1'b0;
        dm_ready_d  = 1'b0;
        err_d       = err_q;
        tmo_d       = tmo_q;
        case (state_q)
            IDLE: begin
                mem_en_d = 1'b0;
                tmo_d    = '0;
                if (dm_go) begin
                    mem_en_d    = 1'b1;
                    mem_we_d    = dm_we;
                    mem_addr_d  = dm_addr;
                    mem_wdata_d = dm_wdata;
                    state_d     = DATA;
                end else if (if_go) begin
                    mem_en_d    = 1'b1;
                    mem_we_d    = 1'b0;
                    mem_addr_d  = if_addr;
                    mem_wdata_d = '0;
                    state_d     = FETCH;
                end
            end
            DATA, FETCH: begin
                if (mem_valid || (tmo_q == TMO_LAST)) begin
                    mem_en_d = 1'b0;
                    mem_we_d = 1'b0;
                    tmo_d    = '0;
                    state_d  = IDLE;
                    if (!mem_valid) begin
                        err_d = 1'b1;
                    end
                    if (state_owner(state_q) == OWN_DM) begin
                        dm_ready_d = 1'b1;
                        if (!mem_valid) begin
                            dm_rdata_d = DW'(ARB_ABORT_DATA);
                        end else if (!mem_we_q) begin
                            dm_rdata_d = mem_rdata;
                        end
                    end else begin
                        if_ready_d = 1'b1;
                        if_rdata_d = mem_valid ? mem_rdata : DW'(ARB_ABORT_DATA);
                    end
                end else begin
                    tmo_d = tmo_q + CW'(1);
                end
            end
            default: begin
                state_d  = IDLE;
                mem_en_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= IDLE;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            if_rdata_q  <= '0;
            dm_rdata_q  <= '0;
            if_ready_q  <= 1'b0;
            dm_ready_q  <= 1'b0;
            err_q       <= 1'b0;
            tmo_q       <= '0;
        end else begin
            state_q     <= state_d;
            mem_en_q    <= mem_en_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            if_rdata_q  <= if_rdata_d;
            dm_rdata_q  <= dm_rdata_d;
            if_ready_q  <= if_ready_d;
            dm_ready_q  <= dm_ready_d;
            err_q       <= err_d;
            tmo_q       <= tmo_d;
        end
    end

    assign mem_en    = mem_en_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign if_rdata  = if_rdata_q;
    assign if_ready  = if_ready_q;
    assign dm_rdata  = dm_rdata_q;
    assign dm_ready  = dm_ready_q;
    assign err       = err_q;

`ifdef PIPE_ARB_PERF_CNT_EN
    pipe_arb_perf_cnt u_conflict_cnt (
        .clock (clock),
        .clr   (reset),
        .inc   ((state_q == IDLE) & dm_go & if_go),
        .cnt   (conflict_cnt)
    );

    pipe_arb_perf_cnt u_fetch_stall_cnt (
        .clock (clock),
        .clr   (reset),
        .inc   (if_req & ~if_ready_q),
        .cnt   (fetch_stall_cnt)
    );
`endif

endmodule

// File: tb/tb_pipe_mem_arbiter.sv
// Randomized transaction-level bench for pipe_mem_arbiter with a memory responder.
module tb_pipe_mem_arbiter;

    localparam int TMO   = 8;
    localparam int NEVER = 1000;
    localparam logic [31:0] ABORT = 32'hDEAD_BEEF;

    logic        clock = 1'b0;
    logic        reset;
    logic        if_req, dm_req, dm_we;
    logic [31:0] if_addr, dm_addr, dm_wdata;
    logic [31:0] if_rdata, dm_rdata;
    logic        if_ready, dm_ready;
    logic        mem_en, mem_we, mem_valid, err;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
`ifdef PIPE_ARB_PERF_CNT_EN
    logic [15:0] conflict_cnt, fetch_stall_cnt;
`endif

    int checks = 0;
    int errors = 0;

    logic [31:0] mem_arr [0:255];
    logic [31:0] exp_mem [0:255];
    logic [31:0] dm_rdata_exp, if_rdata_exp;
    logic        err_exp;
    int          exp_conf;
    int          exp_stall;
    int          lat_q [$];
    bit          busy;
    int          cur_lat, wcnt;

    pipe_mem_arbiter #(.AW(32), .DW(32), .TIMEOUT(TMO)) dut (
        .clock     (clock),
        .reset     (reset),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_rdata  (if_rdata),
        .if_ready  (if_ready),
        .dm_req    (dm_req),
        .dm_we     (dm_we),
        .dm_addr   (dm_addr),
        .dm_wdata  (dm_wdata),
        .dm_rdata  (dm_rdata),
        .dm_ready  (dm_ready),
        .mem_en    (mem_en),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_valid (mem_valid),
        .err       (err)
`ifdef PIPE_ARB_PERF_CNT_EN
        ,
        .conflict_cnt    (conflict_cnt),
        .fetch_stall_cnt (fetch_stall_cnt)
`endif
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%h exp=%h", tag, act, exp);
        end
    endtask

    // Memory: each access takes the next latency from lat_q, counted from mem_en rise.
    always @(negedge clock) begin
        if (!mem_en) begin
            busy      = 1'b0;
            mem_valid = 1'b0;
        end else begin
            if (!busy) begin
                busy    = 1'b1;
                wcnt    = 0;
                cur_lat = (lat_q.size() > 0) ? lat_q.pop_front() : 0;
            end
            if (wcnt == cur_lat) begin
                mem_valid = 1'b1;
                mem_rdata = mem_arr[mem_addr[9:2]];
                if (mem_we) mem_arr[mem_addr[9:2]] = mem_wdata;
            end else begin
                mem_valid = 1'b0;
                mem_rdata = $urandom;
            end
            wcnt++;
        end
    end

    // Stall events as the pipeline sees them: fetch pending, no completion this cycle.
    always @(posedge clock) begin
        if (reset) exp_stall = 0;
        else if (if_req && !if_ready && exp_stall < 65535) exp_stall++;
    end

    task automatic clear_exp();
        dm_rdata_exp = '0;
        if_rdata_exp = '0;
        err_exp      = 1'b0;
        exp_conf     = 0;
        lat_q.delete();
    endtask

    task automatic run_txn(input bit do_dm, input bit we, input logic [31:0] daddr,
                           input logic [31:0] wdata, input int kd, input bit do_if,
                           input logic [31:0] iaddr, input int kf);
        int kde, kfe, n_dm, n_if, if_s, n_last;
        bit ab_d, ab_i, men;
        logic [31:0] exp_d, exp_i;
        ab_d   = do_dm && (kd > TMO - 1);
        ab_i   = do_if && (kf > TMO - 1);
        kde    = ab_d ? TMO - 1 : kd;
        kfe    = ab_i ? TMO - 1 : kf;
        n_dm   = do_dm ? 1 + kde : -10;
        if_s   = do_dm ? n_dm + 1 : 0;
        n_if   = do_if ? if_s + 1 + kfe : -10;
        n_last = ((n_dm > n_if) ? n_dm : n_if) + 2;
        exp_d  = ab_d ? ABORT : (we ? dm_rdata_exp : exp_mem[daddr[9:2]]);
        if (do_dm && we && !ab_d) exp_mem[daddr[9:2]] = wdata;
        exp_i  = ab_i ? ABORT : exp_mem[iaddr[9:2]];
        if (do_dm) lat_q.push_back(kd);
        if (do_if) lat_q.push_back(kf);
        if (do_dm && do_if) exp_conf++;
        dm_req = do_dm; dm_we = we; dm_addr = daddr; dm_wdata = wdata;
        if_req = do_if; if_addr = iaddr;
        for (int n = 0; n <= n_last; n++) begin
            @(negedge clock);
            if (n == n_dm) begin
                dm_rdata_exp = exp_d;
                if (ab_d) err_exp = 1'b1;
            end
            if (n == n_if) begin
                if_rdata_exp = exp_i;
                if (ab_i) err_exp = 1'b1;
            end
            if (n == n_dm + 1) dm_req = 1'b0;
            if (n == n_if + 1) if_req = 1'b0;
            men = (do_dm && n <= kde) || (do_if && n >= if_s && n <= if_s + kfe);
            chk("dm_ready", 32'(dm_ready), 32'(n == n_dm));
            chk("if_ready", 32'(if_ready), 32'(n == n_if));
            chk("dm_rdata", dm_rdata, dm_rdata_exp);
            chk("if_rdata", if_rdata, if_rdata_exp);
            chk("err", 32'(err), 32'(err_exp));
            chk("mem_en", 32'(mem_en), 32'(men));
            if (men && do_dm && n <= kde) begin
                chk("dm_mem_addr", mem_addr, daddr);
                chk("dm_mem_we", 32'(mem_we), 32'(we));
                chk("dm_mem_wdata", mem_wdata, wdata);
            end else if (men) begin
                chk("if_mem_addr", mem_addr, iaddr);
                chk("if_mem_we", 32'(mem_we), 32'd0);
                chk("if_mem_wdata", mem_wdata, 32'd0);
            end
        end
    endtask

    initial begin
        logic [31:0] a0, a1;
        bit d, f;
        for (int i = 0; i < 256; i++) begin
            exp_mem[i] = $urandom;
            mem_arr[i] = exp_mem[i];
        end
        exp_mem[1] = 32'h2001_0005;
        mem_arr[1] = 32'h2001_0005;
        busy = 1'b0; mem_valid = 1'b0; mem_rdata = '0;
        reset = 1'b1; if_req = 1'b0; dm_req = 1'b0; dm_we = 1'b0;
        if_addr = '0; dm_addr = '0; dm_wdata = '0;
        clear_exp();
        repeat (3) @(negedge clock);
        chk("rst_mem_en", 32'(mem_en), 32'd0);
        chk("rst_mem_we", 32'(mem_we), 32'd0);
        chk("rst_mem_addr", mem_addr, 32'd0);
        chk("rst_mem_wdata", mem_wdata, 32'd0);
        chk("rst_ready", {30'd0, if_ready, dm_ready}, 32'd0);
        chk("rst_if_rdata", if_rdata, 32'd0);
        chk("rst_dm_rdata", dm_rdata, 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        reset = 1'b0;

        // Reset arriving mid-fetch abandons the access.
        lat_q.push_back(NEVER);
        if_req = 1'b1; if_addr = 32'h30;
        repeat (3) @(negedge clock);
        chk("midrst_busy", 32'(mem_en), 32'd1);
        reset = 1'b1;
        @(negedge clock);
        chk("midrst_mem_en", 32'(mem_en), 32'd0);
        chk("midrst_if_ready", 32'(if_ready), 32'd0);
        chk("midrst_err", 32'(err), 32'd0);
        repeat (2) @(negedge clock);
        reset = 1'b0; if_req = 1'b0;
        clear_exp();
        repeat (4) begin
            @(negedge clock);
            chk("postrst_if_ready", 32'(if_ready), 32'd0);
            chk("postrst_mem_en", 32'(mem_en), 32'd0);
        end

        run_txn(1'b0, 1'b0, 32'h0, 32'h0, 0, 1'b1, 32'h4, 0);
        run_txn(1'b1, 1'b1, 32'h10, 32'hA5A5_A5A5, 2, 1'b1, 32'h8, 2);
        run_txn(1'b1, 1'b0, 32'h20, $urandom, 5, 1'b0, 32'h0, 0);
        run_txn(1'b0, 1'b0, 32'h0, 32'h0, 0, 1'b1, 32'h10, TMO - 1);

        for (int i = 0; i < 30; i++) begin
            d  = ($urandom_range(0, 2) != 0);
            f  = d ? ($urandom_range(0, 1) != 0) : 1'b1;
            a0 = {22'd0, 8'($urandom_range(0, 255)), 2'b00};
            a1 = {22'd0, 8'($urandom_range(0, 255)), 2'b00};
            run_txn(d, 1'($urandom_range(0, 1)), a0, $urandom, $urandom_range(0, TMO - 1),
                    f, a1, $urandom_range(0, TMO - 1));
        end

        run_txn(1'b1, 1'b0, 32'h40, $urandom, NEVER, 1'b0, 32'h0, 0);
        run_txn(1'b0, 1'b0, 32'h0, 32'h0, 0, 1'b1, 32'h44, 1);
        run_txn(1'b1, 1'b0, 32'h48, $urandom, 3, 1'b0, 32'h0, 0);

`ifdef PIPE_ARB_PERF_CNT_EN
        repeat (2) @(negedge clock);
        chk("conflict_cnt", 32'(conflict_cnt), 32'(exp_conf));
        chk("fetch_stall_cnt", 32'(fetch_stall_cnt), 32'(exp_stall));
`endif

        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        chk("err_cleared", 32'(err), 32'd0);
        chk("final_mem_en", 32'(mem_en), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
